// File: rtl/game_timer_controller.sv
// game_timer_controller: three-digit BCD countdown timer driven by a one-second
// prescaler on CLK100M. LOAD sets the start value, START runs or resumes,
// PAUSE freezes both the digits and the prescaler phase. DONE pulses once on
// expiry.
// Optional feature: define TIMER_WARN_EN to build the low-time WARN output;
// without it WARN is tied to 0.
module game_timer_controller #(
    parameter logic [27:0] DIVISOR = 28'd100000000
) (
    input  logic        CLK100M,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [11:0] LOAD_BCD,
    input  logic        START,
    input  logic        PAUSE,
    output logic [11:0] DIGITS,
    output logic [1:0]  STATE,
    output logic        DONE,
    output logic        WARN
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    localparam logic [27:0] PRESC_LAST = DIVISOR - 28'd1;

    state_t      state_r;
    state_t      state_s;
    logic [11:0] digits_r;
    logic [11:0] digits_s;
    logic [27:0] presc_r;
    logic [27:0] presc_s;
    logic        done_r;
    logic        done_s;
    logic        tick_s;

    // Saturate one BCD digit at 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Clamp each of the three digits independently.
    function automatic logic [11:0] bcd_clamp(input logic [11:0] v);
        return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

    // Decrement a nonzero three-digit BCD value with borrow between digits.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (u != 4'd0) begin
            u = u - 4'd1;
        end else begin
            u = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd9;
                h = h - 4'd1;
            end
        end
        return {h, t, u};
    endfunction

    // A tick only exists while running and the prescaler is on its last count.
    assign tick_s = (state_r == ST_RUNNING) && (presc_r == PRESC_LAST);

    // Next-state logic: LOAD beats PAUSE beats START; counting happens only
    // when no command is acted on in RUNNING.
    always_comb begin
        state_s  = state_r;
        digits_s = digits_r;
        presc_s  = presc_r;
        done_s   = 1'b0;
        if (LOAD) begin
            state_s  = ST_IDLE;
            digits_s = bcd_clamp(LOAD_BCD);
            presc_s  = 28'd0;
        end else if (PAUSE) begin
            // PAUSE wins over START even where it has no effect itself.
            if (state_r == ST_RUNNING) begin
                state_s = ST_PAUSED;
            end else begin
                state_s = state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        if (digits_r == 12'h000) begin
                            state_s = ST_EXPIRED;
                            done_s  = 1'b1;
                            presc_s = 28'd0;
                        end else begin
                            state_s = ST_RUNNING;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (tick_s) begin
                        presc_s = 28'd0;
                        if ((digits_r == 12'h001) || (digits_r == 12'h000)) begin
                            digits_s = 12'h000;
                            state_s  = ST_EXPIRED;
                            done_s   = 1'b1;
                        end else begin
                            digits_s = bcd_dec(digits_r);
                        end
                    end else begin
                        presc_s = presc_r + 28'd1;
                    end
                end
                ST_PAUSED: begin
                    if (START) begin
                        state_s = ST_RUNNING;
                    end else begin
                        state_s = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
                    state_s = ST_EXPIRED;
                    presc_s = 28'd0;
                end
                default: begin
                    state_s = ST_IDLE;
                    presc_s = 28'd0;
                end
            endcase
        end
    end

    // State, digits, prescaler and DONE registers with asynchronous reset.
    always_ff @(posedge CLK100M or posedge RST) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            digits_r <= 12'h000;
            presc_r  <= 28'd0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            digits_r <= digits_s;
            presc_r  <= presc_s;
            done_r   <= done_s;
        end
    end

    assign DIGITS = digits_r;
    assign STATE  = state_r;
    assign DONE   = done_r;

`ifdef TIMER_WARN_EN
    logic warn_r;
    logic warn_s;

    // Warning follows the next state/digits so it changes on the same edge.
    always_comb begin
        warn_s = ((state_s == ST_RUNNING) || (state_s == ST_PAUSED)) &&
                 (digits_s[11:4] == 8'h00);
    end

    // Registered low-time warning.
    always_ff @(posedge CLK100M or posedge RST) begin
        if (RST) begin
            warn_r <= 1'b0;
        end else begin
            warn_r <= warn_s;
        end
    end

    assign WARN = warn_r;
`else
    assign WARN = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_controller.sv
// Scoreboard bench for game_timer_controller with DIVISOR = 4. Expected
// outputs are queued against an absolute clock-edge number when stimulus is
// driven and compared on the following falling edge.
module tb_game_timer_controller;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_EXPIRED = 2'b11;

    logic        CLK100M;
    logic        RST;
    logic        LOAD;
    logic [11:0] LOAD_BCD;
    logic        START;
    logic        PAUSE;
    logic [11:0] DIGITS;
    logic [1:0]  STATE;
    logic        DONE;
    logic        WARN;

    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] digits;
        logic [1:0]  state;
        logic        done;
        logic        warn;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    game_timer_controller #(.DIVISOR(28'd4)) dut (
        .CLK100M (CLK100M),
        .RST     (RST),
        .LOAD    (LOAD),
        .LOAD_BCD(LOAD_BCD),
        .START   (START),
        .PAUSE   (PAUSE),
        .DIGITS  (DIGITS),
        .STATE   (STATE),
        .DONE    (DONE),
        .WARN    (WARN)
    );

    initial begin
        CLK100M = 1'b0;
        forever #5 CLK100M = ~CLK100M;
    end

    initial begin
        cyc = 0;
    end

    // Count rising edges so expectations can name the edge they belong to.
    always @(posedge CLK100M) begin
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Queue the expected outputs after the dly-th upcoming rising edge.
    task automatic push_exp(input int dly, input string tag, input logic [11:0] d,
                            input logic [1:0] st, input logic dn);
        exp_t e;
        e.cyc    = cyc + dly;
        e.tag    = tag;
        e.digits = d;
        e.state  = st;
        e.done   = dn;
`ifdef TIMER_WARN_EN
        e.warn   = ((st == ST_RUNNING) || (st == ST_PAUSED)) && (d[11:4] == 8'h00);
`else
        e.warn   = 1'b0;
`endif
        sb_q.push_back(e);
    endtask

    // Hold the given commands for exactly one rising edge.
    task automatic pulse(input logic l, input logic [11:0] bcd, input logic s, input logic p);
        LOAD     = l;
        LOAD_BCD = bcd;
        START    = s;
        PAUSE    = p;
        @(negedge CLK100M);
        LOAD  = 1'b0;
        START = 1'b0;
        PAUSE = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK100M);
    endtask

    // Wait (bounded) until every queued expectation has been compared.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((sb_q.size() != 0) && (guard < 200)) begin
            @(negedge CLK100M);
            guard++;
        end
        check_eq({tag, "/drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Compare every expectation that is due on this edge.
    always @(negedge CLK100M) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                check_eq({sb_q[i].tag, "/edge"},   32'(cyc),        32'(sb_q[i].cyc));
                check_eq({sb_q[i].tag, "/digits"}, 32'(DIGITS),     32'(sb_q[i].digits));
                check_eq({sb_q[i].tag, "/state"},  32'(STATE),      32'(sb_q[i].state));
                check_eq({sb_q[i].tag, "/done"},   32'(DONE),       32'(sb_q[i].done));
                check_eq({sb_q[i].tag, "/warn"},   32'(WARN),       32'(sb_q[i].warn));
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST      = 1'b0;
        LOAD     = 1'b0;
        LOAD_BCD = 12'h000;
        START    = 1'b0;
        PAUSE    = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 RST = 1'b1;
        #1;
        check_eq("rst_async/digits", 32'(DIGITS), 32'h000);
        check_eq("rst_async/state",  32'(STATE),  32'(ST_IDLE));
        check_eq("rst_async/done",   32'(DONE),   32'd0);
        check_eq("rst_async/warn",   32'(WARN),   32'd0);
        idle_cycles(2);
        RST = 1'b0;
        @(negedge CLK100M);
        check_eq("rst_release/state", 32'(STATE), 32'(ST_IDLE));

        // Full countdown from 012.
        push_exp(1, "load012", 12'h012, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h012, 1'b0, 1'b0);
        push_exp(1,  "start012",  12'h012, ST_RUNNING, 1'b0);
        push_exp(4,  "hold012",   12'h012, ST_RUNNING, 1'b0);
        push_exp(5,  "dec011",    12'h011, ST_RUNNING, 1'b0);
        push_exp(9,  "dec010",    12'h010, ST_RUNNING, 1'b0);
        push_exp(48, "at001",     12'h001, ST_RUNNING, 1'b0);
        push_exp(49, "expire",    12'h000, ST_EXPIRED, 1'b1);
        push_exp(50, "done_once", 12'h000, ST_EXPIRED, 1'b0);
        push_exp(60, "hold_exp",  12'h000, ST_EXPIRED, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        drain("countdown");

        // Borrow across two digits.
        push_exp(1, "load100", 12'h100, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h100, 1'b0, 1'b0);
        push_exp(1, "start100",  12'h100, ST_RUNNING, 1'b0);
        push_exp(5, "borrow099", 12'h099, ST_RUNNING, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        drain("borrow");

        // Pause with prescaler at 2, resume keeps the phase.
        push_exp(1, "load050", 12'h050, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h050, 1'b0, 1'b0);
        push_exp(1, "start050", 12'h050, ST_RUNNING, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        idle_cycles(2);
        push_exp(1,  "pause",        12'h050, ST_PAUSED, 1'b0);
        push_exp(5,  "pause_hold5",  12'h050, ST_PAUSED, 1'b0);
        push_exp(10, "pause_hold10", 12'h050, ST_PAUSED, 1'b0);
        pulse(1'b0, 12'h000, 1'b0, 1'b1);
        idle_cycles(9);
        push_exp(1, "resume",        12'h050, ST_RUNNING, 1'b0);
        push_exp(2, "resume_hold",   12'h050, ST_RUNNING, 1'b0);
        push_exp(3, "resume_dec049", 12'h049, ST_RUNNING, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        drain("pause");

        // All three commands while running: LOAD wins, digits clamped.
        push_exp(1, "all3_load", 12'h959, ST_IDLE, 1'b0);
        push_exp(4, "idle_hold", 12'h959, ST_IDLE, 1'b0);
        pulse(1'b1, 12'hA5F, 1'b1, 1'b1);
        drain("priority_load");
        push_exp(1, "start959", 12'h959, ST_RUNNING, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        push_exp(1, "pause_beats_start", 12'h959, ST_PAUSED, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b1);
        push_exp(1, "paused_pause_start", 12'h959, ST_PAUSED, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b1);
        drain("priority_pause");

        // LOAD on the same edge as the final tick.
        push_exp(1, "load001", 12'h001, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h001, 1'b0, 1'b0);
        push_exp(1, "start001", 12'h001, ST_RUNNING, 1'b0);
        push_exp(3, "run001",   12'h001, ST_RUNNING, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        idle_cycles(3);
        push_exp(1, "load_on_tick",  12'h234, ST_IDLE, 1'b0);
        push_exp(2, "no_done_after", 12'h234, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h234, 1'b0, 1'b0);
        drain("load_tick");

        // START with zero digits expires immediately.
        push_exp(1, "load000", 12'h000, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h000, 1'b0, 1'b0);
        push_exp(1, "start_zero",     12'h000, ST_EXPIRED, 1'b1);
        push_exp(2, "zero_done_once", 12'h000, ST_EXPIRED, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        push_exp(1, "start_in_exp", 12'h000, ST_EXPIRED, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        drain("zero");

        // Low-time warning window from 011.
        push_exp(1, "load011", 12'h011, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h011, 1'b0, 1'b0);
        push_exp(1,  "start011", 12'h011, ST_RUNNING, 1'b0);
        push_exp(8,  "pre_warn", 12'h010, ST_RUNNING, 1'b0);
        push_exp(9,  "warn_009", 12'h009, ST_RUNNING, 1'b0);
        push_exp(44, "warn_001", 12'h001, ST_RUNNING, 1'b0);
        push_exp(45, "warn_exp", 12'h000, ST_EXPIRED, 1'b1);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        drain("warn");

        // Asynchronous reset in the middle of a countdown.
        push_exp(1, "load123", 12'h123, ST_IDLE, 1'b0);
        pulse(1'b1, 12'h123, 1'b0, 1'b0);
        push_exp(1, "start123", 12'h123, ST_RUNNING, 1'b0);
        push_exp(5, "dec122",   12'h122, ST_RUNNING, 1'b0);
        pulse(1'b0, 12'h000, 1'b1, 1'b0);
        drain("pre_reset");
        #2 RST = 1'b1;
        #1;
        check_eq("mid_rst/digits", 32'(DIGITS), 32'h000);
        check_eq("mid_rst/state",  32'(STATE),  32'(ST_IDLE));
        check_eq("mid_rst/done",   32'(DONE),   32'd0);
        check_eq("mid_rst/warn",   32'(WARN),   32'd0);
        @(negedge CLK100M);
        check_eq("mid_rst_held/done",  32'(DONE),  32'd0);
        check_eq("mid_rst_held/state", 32'(STATE), 32'(ST_IDLE));
        RST = 1'b0;
        push_exp(1, "post_rst",      12'h000, ST_IDLE, 1'b0);
        push_exp(8, "post_rst_idle", 12'h000, ST_IDLE, 1'b0);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
